// File: rtl/gf_pkg.sv
// Shared GF(2^M) definitions: FSM state type, field size limit, AES polynomial.
package gf_pkg;

  localparam int         GF_M_MAX = 16;
  localparam logic [7:0] GF_P_AES = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } gf_state_t;

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^M) multiplier: z = x*y mod (x^M + p), shift-and-add form.
module gf_mul #(
  parameter int M = 8
) (
  input  logic [M-1:0] x,
  input  logic [M-1:0] y,
  input  logic [M-1:0] p,
  output logic [M-1:0] z
);

  logic [M-1:0] acc;
  logic [M-1:0] sh;

  // sh tracks x*t^i reduced, so each partial product is already in-field
  always_comb begin
    acc = '0;
    sh  = x;
    for (int i = 0; i < M; i++) begin
      if (y[i]) acc = acc ^ sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? p : '0);
    end
    z = acc;
  end

endmodule

// File: rtl/gf_inv_seq.sv
// Sequential GF(2^M) inverse a^(2^M-2), one square + one multiply per cycle.
// Optional zero-operand flag port out_zero: define GF_INV_ZERO_FLAG_EN.
module gf_inv_seq
  import gf_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out
`ifdef GF_INV_ZERO_FLAG_EN
  ,
  output logic         out_zero
`endif
);

  localparam int            CW   = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  if (M < 2 || M > GF_M_MAX) begin : g_bad_m
    $error("gf_inv_seq: M out of range");
  end

  gf_state_t     state;
  logic [M-1:0]  sq, res, p_q;
  logic [M-1:0]  sq_nx, mul_nx;
  logic [CW-1:0] cnt;

  gf_mul #(.M(M)) u_sqr (.x(sq),  .y(sq), .p(p_q), .z(sq_nx));
  gf_mul #(.M(M)) u_mul (.x(res), .y(sq), .p(p_q), .z(mul_nx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      sq    <= '0;
      res   <= '0;
      p_q   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          sq    <= a;
          res   <= M'(1);
          p_q   <= p;
          cnt   <= '0;
          state <= ST_BUSY;
        end
        ST_BUSY: begin
          sq <= sq_nx;
          // step 0 skips a^1 so the product covers exponents 2..2^(M-1)
          if (cnt != '0) res <= mul_nx;
          if (cnt == LAST) state <= ST_DONE;
          else             cnt   <= cnt + CW'(1);
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out       = out_valid ? res : '0;

`ifdef GF_INV_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       zero_q <= 1'b0;
    else if (in_valid && in_ready)    zero_q <= (a == '0);
  end

  assign out_zero = out_valid & zero_q;
`endif

endmodule
